// File: rtl/alu_div_seq_pkg.sv
// Shared EXU divider definitions: datapath width, iteration counts, FSM encoding.
package alu_div_seq_pkg;
    localparam int XLEN    = 64;
    localparam int DIV_N64 = 64;
    localparam int DIV_N32 = 32;
    localparam int CNT_W   = 6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction
endpackage

// File: rtl/alu_div_seq_if.sv
// Request/result handshake between EXU issue and the sequential divider.
interface alu_div_seq_if
    import alu_div_seq_pkg::*;
();
    logic            div_valid_i;
    logic            div_ready_o;
    logic            signed_valid_i;
    logic            div32_valid_i;
    logic [XLEN-1:0] sr1_data_i;
    logic [XLEN-1:0] sr2_data_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] div_out_o;
    logic [XLEN-1:0] rem_out_o;

    modport master (
        output div_valid_i, signed_valid_i, div32_valid_i, sr1_data_i, sr2_data_i, out_ready_i,
        input  div_ready_o, out_valid_o, div_out_o, rem_out_o
    );
    modport slave (
        input  div_valid_i, signed_valid_i, div32_valid_i, sr1_data_i, sr2_data_i, out_ready_i,
        output div_ready_o, out_valid_o, div_out_o, rem_out_o
    );
endinterface

// File: rtl/alu_div_step.sv
// One radix-2 restoring step: shift in a dividend bit, trial-subtract the divisor.
module alu_div_step
    import alu_div_seq_pkg::*;
(
    input  logic [XLEN:0]   rem_i,
    input  logic            dvd_msb_i,
    input  logic [XLEN-1:0] dsr_i,
    input  logic            w32_i,
    output logic [XLEN:0]   rem_o,
    output logic            q_bit_o
);
    logic [XLEN+1:0] sh;
    logic [XLEN+1:0] diff;

    always_comb begin
        sh      = w32_i ? {{(XLEN-31){1'b0}}, rem_i[31:0], dvd_msb_i} : {rem_i, dvd_msb_i};
        diff    = sh - {2'b00, dsr_i};
        // no borrow out of the trial subtract means rem' >= divisor
        q_bit_o = ~diff[XLEN+1];
        rem_o   = q_bit_o ? diff[XLEN:0] : sh[XLEN:0];
    end
endmodule

// File: rtl/alu_div_seq.sv
// RV64M sequential divider: special cases resolved at accept, magnitudes iterated, signs fixed last.
module alu_div_seq
    import alu_div_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    alu_div_seq_if.slave  bus
);
    div_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [XLEN-1:0] dsr_q, dsr_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic            w32_q, w32_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] div_out_q, div_out_d;
    logic [XLEN-1:0] rem_out_q, rem_out_d;

    logic [XLEN-1:0] op_a, op_b, abs_a, abs_b, res_a, min_neg;
    logic [XLEN-1:0] q_raw, q_fix, r_raw, r_fix;
    logic            sign_a, sign_b, div_zero, ovf;
    logic [XLEN:0]   step_rem;
    logic            step_q;

    alu_div_step u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (w32_q ? dvd_q[31] : dvd_q[XLEN-1]),
        .dsr_i     (dsr_q),
        .w32_i     (w32_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q)
    );

    always_comb begin
        // Word ops see only the low half, extended per signedness for the magnitude path.
        op_a = bus.sr1_data_i;
        op_b = bus.sr2_data_i;
        if (bus.div32_valid_i) begin
            op_a = bus.signed_valid_i ? sext32(bus.sr1_data_i[31:0])
                                      : {{(XLEN-32){1'b0}}, bus.sr1_data_i[31:0]};
            op_b = bus.signed_valid_i ? sext32(bus.sr2_data_i[31:0])
                                      : {{(XLEN-32){1'b0}}, bus.sr2_data_i[31:0]};
        end
        res_a    = bus.div32_valid_i ? sext32(bus.sr1_data_i[31:0]) : bus.sr1_data_i;
        min_neg  = bus.div32_valid_i ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        sign_a   = bus.signed_valid_i & op_a[XLEN-1];
        sign_b   = bus.signed_valid_i & op_b[XLEN-1];
        abs_a    = sign_a ? -op_a : op_a;
        abs_b    = sign_b ? -op_b : op_b;
        div_zero = (op_b == '0);
        ovf      = bus.signed_valid_i && (op_a == min_neg) && (op_b == '1);

        q_raw = w32_q ? {{(XLEN-32){1'b0}}, dvd_q[31:0]} : dvd_q;
        r_raw = w32_q ? {{(XLEN-32){1'b0}}, rem_q[31:0]} : rem_q[XLEN-1:0];
        q_fix = q_neg_q ? -q_raw : q_raw;
        r_fix = r_neg_q ? -r_raw : r_raw;

        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        rem_d       = rem_q;
        w32_d       = w32_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        out_valid_d = out_valid_q;
        div_out_d   = div_out_q;
        rem_out_d   = rem_out_q;

        unique case (state_q)
            DIV_IDLE: begin
                if (bus.div_valid_i) begin
                    w32_d = bus.div32_valid_i;
                    if (div_zero) begin
                        div_out_d   = '1;
                        rem_out_d   = res_a;
                        out_valid_d = 1'b1;
                        state_d     = DIV_DONE;
                    end else if (ovf) begin
                        div_out_d   = res_a;
                        rem_out_d   = '0;
                        out_valid_d = 1'b1;
                        state_d     = DIV_DONE;
                    end else begin
                        dvd_d   = abs_a;
                        dsr_d   = abs_b;
                        rem_d   = '0;
                        q_neg_d = sign_a ^ sign_b;
                        r_neg_d = sign_a;
                        cnt_d   = bus.div32_valid_i ? CNT_W'(DIV_N32 - 1) : CNT_W'(DIV_N64 - 1);
                        state_d = DIV_CALC;
                    end
                end
            end
            DIV_CALC: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[XLEN-2:0], step_q};
                if (cnt_q == '0) state_d = DIV_FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DIV_FIX: begin
                div_out_d   = w32_q ? sext32(q_fix[31:0]) : q_fix;
                rem_out_d   = w32_q ? sext32(r_fix[31:0]) : r_fix;
                out_valid_d = 1'b1;
                state_d     = DIV_DONE;
            end
            DIV_DONE: begin
                if (bus.out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase

        // Redirect wins over everything, including a request or result handshake this cycle.
        if (flush_i) begin
            state_d     = DIV_IDLE;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DIV_IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            rem_q       <= '0;
            w32_q       <= 1'b0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            out_valid_q <= 1'b0;
            div_out_q   <= '0;
            rem_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            rem_q       <= rem_d;
            w32_q       <= w32_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            out_valid_q <= out_valid_d;
            div_out_q   <= div_out_d;
            rem_out_q   <= rem_out_d;
        end
    end

    assign bus.div_ready_o = (state_q == DIV_IDLE);
    assign bus.out_valid_o = out_valid_q;
    assign bus.div_out_o   = div_out_q;
    assign bus.rem_out_o   = rem_out_q;
endmodule

// File: doc/alu_div_seq.md
# alu_div_seq

Multi-cycle sequencer for the RV64M integer divider: accepts one DIV/DIVU/REM/REMU/DIVW/DIVUW/REMW/REMUW operation through a valid/ready handshake and runs a radix-2 restoring shift-subtract loop over 64 or 32 iterations. It produces quotient and remainder together, resolving the RISC-V divide-by-zero and signed-overflow cases without iterating. It sits in the EXU beside the combinational ALU, stalling issue until its result is taken, and replaces the single-cycle `/` and `%` path for timing closure.

## Interface
- XLEN, 64, datapath width (from the system config define)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- div_valid_i  in  1  request valid
- div_ready_o  out  1  block can accept; high exactly when state is IDLE
- signed_valid_i  in  1  1 = signed op (DIV/REM/DIVW/REMW)
- div32_valid_i  in  1  1 = word op; only bits [31:0] of the operands are used
- sr1_data_i  in  XLEN  dividend
- sr2_data_i  in  XLEN  divisor
- flush_i  in  1  abort the in-flight op (pipeline redirect)
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- div_out_o  out  XLEN  quotient
- rem_out_o  out  XLEN  remainder

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE**
  - On `div_valid_i & div_ready_o & ~flush_i`, latch the operation and compute N = 32 if word, else 64.
  - Divisor zero (sr2[N-1:0] == 0): quotient = all ones, remainder = dividend. Go to DONE.
  - Signed overflow (dividend = −2^(N−1), divisor = −1): quotient = dividend, remainder = 0. Go to DONE.
  - Otherwise: latch |dividend| and |divisor| (absolute value only when signed), latch `q_neg` = sign1 ^ sign2 and `r_neg` = sign1, clear the partial remainder, load counter = N−1, go to CALC.
- **CALC**, one step per cycle:
  - rem' = {rem[N−1:0], dvd[N−1]}; dvd shifts left.
  - If rem' ≥ divisor: rem' −= divisor and the shifted-in quotient bit is 1; else it is 0.
  - Partial remainder register is N+1 bits.
  - When counter == 0, go to FIX; else decrement the counter.
- **FIX**
  - Negate the quotient if `q_neg`; negate the remainder if `r_neg`.
  - Word ops: sign-extend bit 31 of both results to XLEN. This applies to DIVUW/REMUW as well.
  - Register the results into `div_out_o`/`rem_out_o` and go to DONE.
- **DONE**
  - `out_valid_o` = 1; outputs held stable until `out_ready_i`.
  - On `out_ready_i`, go to IDLE.
- **Flush**
  - `flush_i` in any state forces IDLE on the next edge, drops the op and deasserts `out_valid_o`.
  - A flush in the same cycle as a request means the request is not accepted.
  - Flush has priority over `out_ready_i`.
- **Reset**
  - State IDLE, `out_valid_o` = 0, `div_out_o` = `rem_out_o` = 0, counter 0.
  - Reset mid-CALC discards the op.

## Timing
- Accept edge t. Normal op: `out_valid_o` rises at t+N+2, i.e. 66 cycles for 64-bit and 34 cycles for word ops.
- Special case (divide-by-zero or overflow): `out_valid_o` at t+1.
- `div_ready_o` is low from t+1 until the cycle after the result handshake. There is no back-to-back accept in the result-handshake cycle.
- `div_ready_o` depends only on state, with no combinational path from `div_valid_i` or `out_ready_i`.
- `out_valid_o`, `div_out_o` and `rem_out_o` are registered.
- `out_ready_i` held low keeps DONE indefinitely with outputs unchanged.

## Structure
- A shared EXU package or config header holds:
  - the state encoding (2-bit: IDLE=0, CALC=1, FIX=2, DONE=3);
  - the iteration counts DIV_N64 = 64 and DIV_N32 = 32;
  - `XLEN` from the system config.
- One sub-module, `alu_div_step`: combinational one-bit restoring step.
  - Inputs: rem, dvd MSB, divisor, width select.
  - Outputs: next rem, quotient bit.
  - This keeps the iteration datapath separately unit-testable.
- The sign pre/post-processing and special-case detection stay in `alu_div_seq`.

## Test plan
- DIV 64-bit, sr1 = 100, sr2 = −7 → quotient −14 (0xFFFFFFFFFFFFFFF2), remainder 2, `out_valid_o` at t+66.
- DIVUW, sr1 = 0x00000000_FFFFFFFE, sr2 = 1 → quotient 0xFFFFFFFF_FFFFFFFE (sign-extended), remainder 0, at t+34.
- DIV by zero, sr1 = 5, sr2 = 0 → quotient all ones, remainder 5, at t+1. REMW, sr1 = 0x80000000, sr2 = 0 → remainder 0xFFFFFFFF_80000000.
- DIV signed overflow, sr1 = 0x8000000000000000, sr2 = −1 → quotient 0x8000000000000000, remainder 0, at t+1. DIVW with 0x80000000 / −1 → quotient 0xFFFFFFFF_80000000.
- Flush at t+10 of a 64-bit op → IDLE and `div_ready_o` = 1 at t+11, no `out_valid_o`. A new REMU with sr1 = 17, sr2 = 5 then gives remainder 2.
- Backpressure: hold `out_ready_i` = 0 for 20 cycles in DONE → outputs stable. Assert `rst` mid-CALC → `out_valid_o` = 0 and `div_ready_o` = 1 on the next cycle.
